// File: rtl/pwm_multi_core_if.sv
// Register-side bundle for the multi-channel PWM core: requested settings in,
// timebase status and PWM outputs back.
interface pwm_multi_core_if #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CNT_WIDTH = 32
);
  logic                        enable;
  logic [CNT_WIDTH-1:0]        period_cycles_i;
  logic [NUM_CH*CNT_WIDTH-1:0] duty_cycles_i;
  logic                        center_mode_i;
  logic [NUM_CH-1:0]           polarity_i;
  logic [NUM_CH-1:0]           ch_en_i;
  logic                        update_req_i;
  logic                        update_pending_o;
  logic [CNT_WIDTH-1:0]        cnt_o;
  logic                        dir_down_o;
  logic                        period_end_o;
  logic [NUM_CH-1:0]           pwm_o;

  modport master (
    output enable, period_cycles_i, duty_cycles_i, center_mode_i, polarity_i,
           ch_en_i, update_req_i,
    input  update_pending_o, cnt_o, dir_down_o, period_end_o, pwm_o
  );

  modport slave (
    input  enable, period_cycles_i, duty_cycles_i, center_mode_i, polarity_i,
           ch_en_i, update_req_i,
    output update_pending_o, cnt_o, dir_down_o, period_end_o, pwm_o
  );
endinterface

// File: rtl/pwm_multi_core.sv
// Multi-channel PWM core: shared edge/center-aligned timebase with double-buffered
// period, duty, mode and polarity committed atomically at period boundaries.
module pwm_multi_core #(
  parameter int unsigned NUM_CH                = 4,
  parameter int unsigned CNT_WIDTH             = 32,
  parameter int unsigned DEFAULT_PERIOD_CYCLES = 5000,
  parameter int unsigned DEFAULT_DUTY_CYCLES   = 2500
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pwm_multi_core_if.slave        bus
);
  typedef enum logic {MODE_EDGE = 1'b0, MODE_CENTER = 1'b1} mode_t;

  localparam logic [CNT_WIDTH-1:0] DEF_PERIOD = CNT_WIDTH'(DEFAULT_PERIOD_CYCLES);
  localparam logic [CNT_WIDTH-1:0] DEF_DUTY   = CNT_WIDTH'(DEFAULT_DUTY_CYCLES);
  localparam logic [CNT_WIDTH-1:0] ONE        = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] act_period, stg_period;
  logic [CNT_WIDTH-1:0] act_duty [NUM_CH];
  logic [CNT_WIDTH-1:0] stg_duty [NUM_CH];
  mode_t                act_mode, stg_mode;
  logic [NUM_CH-1:0]    act_pol, stg_pol;
  logic                 pending;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 dir_down;
  logic [NUM_CH-1:0]    pwm;

  logic                 at_top;
  logic                 period_end;
  logic                 commit;
  logic [NUM_CH-1:0]    raw;

  always_comb begin
    at_top     = (cnt == act_period - ONE);
    period_end = 1'b0;
    if (bus.enable) begin
      if (act_mode == MODE_EDGE) period_end = at_top;
      else                       period_end = dir_down && (cnt == '0);
    end
    commit = pending && (period_end || !bus.enable);
    raw = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) raw[k] = (cnt < act_duty[k]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act_period <= DEF_PERIOD;
      stg_period <= DEF_PERIOD;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        act_duty[k] <= DEF_DUTY;
        stg_duty[k] <= DEF_DUTY;
      end
      act_mode <= MODE_EDGE;
      stg_mode <= MODE_EDGE;
      act_pol  <= '0;
      stg_pol  <= '0;
      pending  <= 1'b0;
      cnt      <= '0;
      dir_down <= 1'b0;
      pwm      <= '0;
    end else begin
      if (bus.update_req_i) begin
        stg_period <= bus.period_cycles_i;
        for (int unsigned k = 0; k < NUM_CH; k++)
          stg_duty[k] <= bus.duty_cycles_i[k*CNT_WIDTH +: CNT_WIDTH];
        stg_mode <= bus.center_mode_i ? MODE_CENTER : MODE_EDGE;
        stg_pol  <= bus.polarity_i;
      end
      // Commit uses the staging contents from before any same-cycle request,
      // which then stays pending for the following boundary.
      if (commit) begin
        act_period <= (stg_period == '0) ? DEF_PERIOD : stg_period;
        for (int unsigned k = 0; k < NUM_CH; k++) act_duty[k] <= stg_duty[k];
        act_mode <= stg_mode;
        act_pol  <= stg_pol;
      end
      pending <= bus.update_req_i || (pending && !commit);

      if (!bus.enable) begin
        cnt      <= '0;
        dir_down <= 1'b0;
      end else if (act_mode == MODE_EDGE) begin
        cnt      <= at_top ? '0 : cnt + ONE;
        dir_down <= 1'b0;
      end else if (!dir_down) begin
        // Top value is held for one extra cycle while direction flips.
        if (at_top) dir_down <= 1'b1;
        else        cnt      <= cnt + ONE;
      end else begin
        if (cnt == '0) dir_down <= 1'b0;
        else           cnt      <= cnt - ONE;
      end

      for (int unsigned k = 0; k < NUM_CH; k++)
        pwm[k] <= (bus.enable && bus.ch_en_i[k]) ? (raw[k] ^ act_pol[k]) : act_pol[k];
    end
  end

  assign bus.update_pending_o = pending;
  assign bus.cnt_o            = cnt;
  assign bus.dir_down_o       = dir_down;
  assign bus.period_end_o     = period_end;
  assign bus.pwm_o            = pwm;
endmodule

// File: tb/tb_pwm_multi_core.sv
// Scoreboard bench for pwm_multi_core: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_pwm_multi_core;
  localparam int K_PWM  = 0;
  localparam int K_CNT  = 1;
  localparam int K_PE   = 2;
  localparam int K_PEND = 3;
  localparam int K_DIR  = 4;

  typedef struct {
    int unsigned cyc;
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int unsigned checks;
  int unsigned errors;
  exp_t        sb[$];

  pwm_multi_core_if #(.NUM_CH(4), .CNT_WIDTH(32)) bus ();

  pwm_multi_core #(
    .NUM_CH(4),
    .CNT_WIDTH(32),
    .DEFAULT_PERIOD_CYCLES(5000),
    .DEFAULT_DUTY_CYCLES(2500)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input int kind);
    case (kind)
      K_PWM:   return {28'd0, bus.pwm_o};
      K_CNT:   return bus.cnt_o;
      K_PE:    return {31'd0, bus.period_end_o};
      K_PEND:  return {31'd0, bus.update_pending_o};
      default: return {31'd0, bus.dir_down_o};
    endcase
  endfunction

  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        act = sample(sb[i].kind);
        checks++;
        if (act !== sb[i].exp) begin
          errors++;
          $display("FAIL %s got %0h expected %0h (cycle %0d)", sb[i].name, act, sb[i].exp, cyc);
        end
        sb.delete(i);
      end
    end
  end

  task automatic expect_at(input int unsigned d, input int kind, input logic [31:0] v,
                           input string nm);
    exp_t e;
    e.cyc  = cyc + d;
    e.kind = kind;
    e.exp  = v;
    e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic request(input logic [31:0] per, input logic [127:0] duty,
                         input logic center, input logic [3:0] pol);
    bus.period_cycles_i = per;
    bus.duty_cycles_i   = duty;
    bus.center_mode_i   = center;
    bus.polarity_i      = pol;
    bus.update_req_i    = 1'b1;
  endtask

  initial begin
    rst_n               = 1'b0;
    bus.enable          = 1'b0;
    bus.period_cycles_i = '0;
    bus.duty_cycles_i   = '0;
    bus.center_mode_i   = 1'b0;
    bus.polarity_i      = '0;
    bus.ch_en_i         = 4'hF;
    bus.update_req_i    = 1'b0;
    checks = 0;
    errors = 0;

    // Reset state
    step(3);
    checks++;
    if (bus.cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL direct_rst_cnt got %0h", bus.cnt_o);
    end
    checks++;
    if (bus.pwm_o !== 4'h0) begin
      errors++;
      $display("FAIL direct_rst_pwm got %0h", bus.pwm_o);
    end
    checks++;
    if (bus.update_pending_o !== 1'b0) begin
      errors++;
      $display("FAIL direct_rst_pending got %0b", bus.update_pending_o);
    end
    checks++;
    if (bus.period_end_o !== 1'b0) begin
      errors++;
      $display("FAIL direct_rst_period_end got %0b", bus.period_end_o);
    end
    checks++;
    if (bus.dir_down_o !== 1'b0) begin
      errors++;
      $display("FAIL direct_rst_dir got %0b", bus.dir_down_o);
    end
    expect_at(1, K_PWM,  0, "rst_pwm");
    expect_at(1, K_CNT,  0, "rst_cnt");
    expect_at(1, K_PEND, 0, "rst_pending");
    expect_at(1, K_DIR,  0, "rst_dir");
    expect_at(1, K_PE,   0, "rst_period_end");
    step(1);

    // Default 5000-cycle period, 2500 duty
    rst_n = 1'b1;
    bus.enable = 1'b1;
    expect_at(1,    K_CNT, 1,    "def_cnt_start");
    expect_at(1,    K_PWM, 4'hF, "def_pwm_first");
    expect_at(2500, K_PWM, 4'hF, "def_pwm_last_high");
    expect_at(2501, K_PWM, 4'h0, "def_pwm_first_low");
    expect_at(4998, K_PE,  0,    "def_pe_early");
    expect_at(4999, K_PE,  1,    "def_pe");
    expect_at(4999, K_CNT, 4999, "def_cnt_top");
    expect_at(5000, K_CNT, 0,    "def_cnt_wrap");
    expect_at(5000, K_PWM, 4'h0, "def_pwm_wrap");
    expect_at(5001, K_PWM, 4'hF, "def_pwm_second");
    step(5001);

    // Mid-period edge-mode update: P=10, duties ch3..ch0 = 5,10,0,3
    request(32'd10, {32'd5, 32'd10, 32'd0, 32'd3}, 1'b0, 4'h0);
    expect_at(1,    K_PEND, 1,    "upd_pending_set");
    expect_at(4998, K_PE,   1,    "upd_old_boundary");
    expect_at(4998, K_PEND, 1,    "upd_pending_hold");
    expect_at(4999, K_CNT,  0,    "upd_cnt_restart");
    expect_at(4999, K_PEND, 0,    "upd_pending_clear");
    expect_at(4999, K_PWM,  4'h0, "upd_pwm_old_tail");
    expect_at(5000, K_PWM,  4'hD, "upd_pwm_j1");
    expect_at(5002, K_PWM,  4'hD, "upd_pwm_j3");
    expect_at(5003, K_PWM,  4'hC, "upd_pwm_j4");
    expect_at(5005, K_PWM,  4'h4, "upd_pwm_j6");
    expect_at(5008, K_PE,   1,    "upd_pe_p10");
    expect_at(5008, K_CNT,  9,    "upd_cnt_top");
    expect_at(5009, K_PWM,  4'h4, "upd_pwm_wrap");
    step(1);
    bus.update_req_i = 1'b0;
    step(5009);

    // Request coincident with period_end: center mode P=8, duty 2
    expect_at(8, K_PE, 1, "coin_pe");
    step(8);
    request(32'd8, {4{32'd2}}, 1'b1, 4'h0);
    expect_at(1,  K_PEND, 1, "coin_pending");
    expect_at(1,  K_CNT,  0, "coin_not_committed_cnt");
    expect_at(10, K_PE,   1, "coin_deferred_pe");
    expect_at(10, K_PEND, 1, "coin_still_pending");
    expect_at(11, K_PEND, 0, "coin_committed");
    expect_at(11, K_PWM,  4'h4, "coin_pwm_old");
    expect_at(14, K_PWM,  4'h0, "ctr_pwm_m3");
    expect_at(18, K_CNT,  7, "ctr_cnt_top_up");
    expect_at(18, K_DIR,  0, "ctr_dir_up");
    expect_at(19, K_CNT,  7, "ctr_cnt_top_down");
    expect_at(19, K_DIR,  1, "ctr_dir_down");
    expect_at(25, K_PWM,  4'h0, "ctr_pwm_m14");
    expect_at(26, K_CNT,  0, "ctr_cnt_bottom");
    expect_at(26, K_PE,   1, "ctr_pe");
    expect_at(26, K_PWM,  4'hF, "ctr_pwm_m15");
    expect_at(27, K_DIR,  0, "ctr_dir_wrap");
    expect_at(27, K_PE,   0, "ctr_pe_clear");
    expect_at(29, K_PWM,  4'hF, "ctr_pwm_m18");
    expect_at(30, K_PWM,  4'h0, "ctr_pwm_m19");
    step(1);
    bus.update_req_i = 1'b0;
    step(29);

    // enable=0: counter idle, update commits within 2 cycles
    bus.enable = 1'b0;
    expect_at(1, K_CNT, 0,    "dis_cnt");
    expect_at(1, K_PWM, 4'h0, "dis_pwm");
    expect_at(1, K_PE,  0,    "dis_pe");
    expect_at(1, K_DIR, 0,    "dis_dir");
    step(1);
    bus.ch_en_i = 4'hE;
    request(32'd0, '0, 1'b0, 4'h3);
    expect_at(1, K_PEND, 1,    "dis_pending");
    expect_at(2, K_PEND, 0,    "dis_commit");
    expect_at(2, K_PWM,  4'h0, "dis_pwm_oldpol");
    expect_at(3, K_PWM,  4'h3, "dis_pwm_idle_pol");
    expect_at(3, K_CNT,  0,    "dis_cnt_held");
    step(1);
    bus.update_req_i = 1'b0;
    step(2);

    // Re-enable: duty 0 gives constant polarity, ch_en=0 gives idle=polarity, period 0 -> 5000
    bus.enable = 1'b1;
    expect_at(1,    K_PWM, 4'h3, "zero_duty_pwm");
    expect_at(1,    K_CNT, 1,    "reen_cnt");
    expect_at(100,  K_PWM, 4'h3, "zero_duty_pwm_mid");
    expect_at(4999, K_PE,  1,    "p0_default_pe");
    expect_at(5000, K_CNT, 0,    "p0_default_wrap");
    step(5003);

    // Reset mid-period with an update pending
    request(32'd10, {4{32'd7}}, 1'b1, 4'hF);
    expect_at(1, K_PEND, 1, "rst2_pending_before");
    step(1);
    bus.update_req_i = 1'b0;
    rst_n = 1'b0;
    expect_at(1, K_PEND, 0,    "rst2_pending");
    expect_at(1, K_CNT,  0,    "rst2_cnt");
    expect_at(1, K_PWM,  4'h0, "rst2_pwm");
    expect_at(1, K_DIR,  0,    "rst2_dir");
    step(1);
    rst_n = 1'b1;
    bus.ch_en_i = 4'hF;
    expect_at(1,    K_PWM,  4'hF, "rst2_pwm_default");
    expect_at(1,    K_CNT,  1,    "rst2_cnt_run");
    expect_at(4999, K_PE,   1,    "rst2_default_pe");
    expect_at(4999, K_CNT,  4999, "rst2_cnt_top");
    expect_at(5000, K_PEND, 0,    "rst2_no_late_commit");
    expect_at(5000, K_CNT,  0,    "rst2_cnt_wrap");
    step(5003);

    foreach (sb[i]) begin
      errors++;
      $display("FAIL %s never sampled expected %0h", sb[i].name, sb[i].exp);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
